icache_nway: RTL and testbench
==============================

ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 Parameters SHALL be: BUS_DATA_WIDTH, default 64, bus data width; BUS_TAG_WIDTH, default 13, bus tag width; WAYS, default 2, associativity, power of 2, 1..8; SETS, default 512, power of 2; LINE_BYTES, default 64, power of 2, multiple of BUS_DATA_WIDTH/8.
REQ-002 Clocking: reset reset, synchronous, active-high; clock clk.
REQ-003 clk  in  1  clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  fetch request, held until resp_valid.
REQ-006 req_addr  in  64  fetch byte address; bit 2 selects the 32-bit half.
REQ-007 flush  in  1  one-cycle pulse requesting invalidate-all.
REQ-008 resp_valid  out  1  fetched word valid.
REQ-009 resp_data  out  32  fetched instruction.
REQ-010 busy  out  1  miss handling or flush in progress.
REQ-011 bus_assert  out  1  bus ownership request to the arbiter.
REQ-012 bus_grant  in  1  arbiter grant.
REQ-013 bus_reqcyc, bus_req[BUS_DATA_WIDTH], bus_reqtag[BUS_TAG_WIDTH]  out  bus request.
REQ-014 bus_reqack  in  1  request accepted.
REQ-015 bus_respcyc, bus_resp[BUS_DATA_WIDTH], bus_resptag[BUS_TAG_WIDTH]  in  bus response beat.
REQ-016 bus_respack  out  1  beat accepted.
REQ-017 hit_count, miss_count  out  32 each  saturating event counters.

Function
REQ-018 Address split SHALL be: offset = low log2(LINE_BYTES) bits; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-019 The FSM SHALL have states IDLE, BUS_WAIT, REQ, WAIT_RESP, FILL, FLUSH.
REQ-020 IDLE, req_valid, tag match on a valid way: resp_valid=1 next cycle; resp_data = addr[2] ? upper 32 bits : lower 32 bits of the selected beat word; hit_count increments.
REQ-021 Back-to-back hits SHALL sustain one response per cycle.
REQ-022 IDLE, req_valid, miss: miss_count increments once per miss; go to REQ if bus_grant else BUS_WAIT; bus_assert=1 from that cycle until fill end or abort.
REQ-023 REQ: bus_reqcyc=1, bus_req=req_addr with offset bits zeroed, bus_reqtag={SYSBUS_READ,SYSBUS_MEMORY} codes from the system bus definitions; leave on bus_reqack to WAIT_RESP.
REQ-024 WAIT_RESP/FILL: each cycle with bus_respcyc=1 SHALL write one beat to the victim way at beat counter position, assert bus_respack, increment counter.
REQ-025 Beats per line = LINE_BYTES*8/BUS_DATA_WIDTH; after the last beat, victim becomes valid with new tag, victim pointer advances (mod WAYS), bus_assert drops, return to IDLE; pending request then hits.
REQ-026 Victim SHALL be the lowest-numbered invalid way in the set, else the set's round-robin pointer.
REQ-027 Victim valid bit SHALL clear when the first fill beat is written.
REQ-028 Loss of bus_grant in REQ, WAIT_RESP or FILL SHALL abort: beat counter=0, victim stays invalid, go to BUS_WAIT, restart the request when granted.
REQ-029 Lines SHALL be written only by fills; stale data SHALL never be returned as a hit.
REQ-030 flush in IDLE SHALL enter FLUSH, clearing one set's valid bits per cycle for SETS cycles, busy=1, then IDLE.
REQ-031 flush outside IDLE SHALL be latched pending and taken on the next IDLE entry, before any lookup.
REQ-032 req_valid dropping mid-miss SHALL still complete the fill; no resp_valid is produced.
REQ-033 Counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-034 reset SHALL force IDLE, clear all valid bits, round-robin pointers, beat counter, pending flush and both counters, and drive every output to 0.
REQ-035 reset mid-fill SHALL discard the fill; the next cycle is IDLE with all outputs 0.

Verification
REQ-036 Cold miss: req 0x1004, grant=1, 8 beats D0..D7 -> bus_req=0x1000, one miss, resp_data=D0[63:32], miss_count=1, hit_count=1.
REQ-037 Hit stream: after REQ-036, requests 0x1000, 0x1008, 0x103C on consecutive cycles -> three consecutive resp_valid with D0[31:0], D1[31:0], D7[63:32].
REQ-038 Eviction: WAYS=2, fill tags A, B, then C in one set -> C replaces A; a request to A misses.
REQ-039 Grant loss: grant drops after beat 3 -> bus_respack stops, request reissued on regrant, line valid only after all 8 beats.
REQ-040 Flush: flush during FILL -> fill completes, FLUSH lasts SETS cycles with busy=1, next request to that line misses.
REQ-041 Reset at beat 5 -> outputs 0 next cycle; the same address misses afterwards.

Source files
------------

// File: rtl/icache_nway_if.sv
// -----------------------------------------------------------------------------
// icache_nway_if
// System-bus connection between the instruction cache (master) and the bus
// arbiter / memory side (slave).
//   bus_assert   master->slave  bus ownership request
//   bus_grant    slave->master  ownership granted
//   bus_reqcyc   master->slave  request cycle valid
//   bus_req      master->slave  request address
//   bus_reqtag   master->slave  request kind {read/write, target}
//   bus_reqack   slave->master  request accepted
//   bus_respcyc  slave->master  response beat valid
//   bus_resp     slave->master  response beat data
//   bus_resptag  slave->master  response tag
//   bus_respack  master->slave  response beat accepted
// -----------------------------------------------------------------------------
interface icache_nway_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_assert;
    logic                      bus_grant;
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_assert, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_grant, bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_assert, bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_grant, bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/icache_nway.sv
// -----------------------------------------------------------------------------
// icache_nway
// N-way set-associative, read-only instruction cache. Hits in IDLE return a
// 32-bit instruction one cycle later, one per cycle. Misses fetch a whole line
// over the system bus into a victim way (lowest invalid way, else the set's
// round-robin pointer). A flush invalidates one set per cycle.
// Ports:
//   clk, reset                synchronous active-high reset
//   req_valid_i, req_addr_i   fetch request (held until resp_valid_o)
//   flush_i                   one-cycle invalidate-all request
//   resp_valid_o, resp_data_o fetched instruction
//   busy_o                    miss handling or flush in progress
//   hit_count_o, miss_count_o saturating event counters
//   bus                       system bus (icache_nway_if.master)
// -----------------------------------------------------------------------------
module icache_nway #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int WAYS           = 2,
    parameter int SETS           = 512,
    parameter int LINE_BYTES     = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid_i,
    input  logic [63:0]   req_addr_i,
    input  logic          flush_i,
    output logic          resp_valid_o,
    output logic [31:0]   resp_data_o,
    output logic          busy_o,
    output logic [31:0]   hit_count_o,
    output logic [31:0]   miss_count_o,
    icache_nway_if.master bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;
    localparam int WORD_B = $clog2(BUS_DATA_WIDTH / 8);
    localparam int BEATS  = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Read of main memory: {SYSBUS_READ, SYSBUS_MEMORY}
    localparam logic                     SYSBUS_READ   = 1'b1;
    localparam logic [BUS_TAG_WIDTH-2:0] SYSBUS_MEMORY = '0;
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG       = {SYSBUS_READ, SYSBUS_MEMORY};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BUS_WAIT  = 3'd1,
        REQ       = 3'd2,
        WAIT_RESP = 3'd3,
        FILL      = 3'd4,
        FLUSH     = 3'd5
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Storage
    logic [BUS_DATA_WIDTH-1:0] data_q [WAYS][SETS*(2**BEAT_W)];
    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    logic [SETS-1:0]           valid_q[WAYS];
    logic [WAY_W-1:0]          rr_q   [SETS];

    // Control state
    state_e            state_q, state_d;
    logic [63:0]       miss_addr_q, miss_addr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]  flush_idx_q, flush_idx_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [TAG_W-1:0]          req_tag_s, miss_tag_s;
    logic [IDX_W-1:0]          req_idx_s, miss_idx_s;
    logic [BEAT_W-1:0]         req_beat_s;
    logic                      hit_s;
    logic [WAY_W-1:0]          hit_way_s, victim_s;
    logic [BUS_DATA_WIDTH-1:0] hit_word_s;
    logic                      fill_we_s, fill_done_s;
    logic                      bus_assert_s, reqcyc_s, respack_s;
    logic                      unused_ok_s;

    assign req_tag_s  = req_addr_i[63 -: TAG_W];
    assign req_idx_s  = req_addr_i[OFF_W +: IDX_W];
    assign req_beat_s = req_addr_i[WORD_B +: BEAT_W];
    assign miss_tag_s = miss_addr_q[63 -: TAG_W];
    assign miss_idx_s = miss_addr_q[OFF_W +: IDX_W];
    assign hit_word_s = data_q[hit_way_s][{req_idx_s, req_beat_s}];
    assign unused_ok_s = ^{req_addr_i[1:0], bus.bus_resptag};

    // Tag compare across all ways of the requested set
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_s && valid_q[w][req_idx_s] && (tag_q[w][req_idx_s] == req_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WAY_W'(w);
            end else begin
                hit_way_s = hit_way_s;
            end
        end
    end

    // Victim select: scanning downward leaves the lowest invalid way
    always_comb begin
        victim_s = rr_q[req_idx_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx_s]) begin
                victim_s = WAY_W'(w);
            end else begin
                victim_s = victim_s;
            end
        end
    end

    // FSM next state, counters and bus handshake
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        victim_d     = victim_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q | flush_i;
        flush_idx_d  = flush_idx_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        fill_we_s    = 1'b0;
        fill_done_s  = 1'b0;
        bus_assert_s = 1'b0;
        reqcyc_s     = 1'b0;
        respack_s    = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending or fresh flush wins over any lookup
                if (flush_i || flush_pend_q) begin
                    state_d      = FLUSH;
                    flush_idx_d  = '0;
                    flush_pend_d = 1'b0;
                end else if (req_valid_i && hit_s) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = req_addr_i[2] ? hit_word_s[63:32] : hit_word_s[31:0];
                    hit_cnt_d    = sat_inc(hit_cnt_q);
                end else if (req_valid_i) begin
                    miss_cnt_d   = sat_inc(miss_cnt_q);
                    miss_addr_d  = {req_addr_i[63:OFF_W], {OFF_W{1'b0}}};
                    victim_d     = victim_s;
                    beat_d       = '0;
                    bus_assert_s = 1'b1;
                    state_d      = bus.bus_grant ? REQ : BUS_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            BUS_WAIT: begin
                bus_assert_s = 1'b1;
                state_d      = bus.bus_grant ? REQ : BUS_WAIT;
            end
            REQ: begin
                bus_assert_s = 1'b1;
                reqcyc_s     = bus.bus_grant;
                if (!bus.bus_grant) begin
                    beat_d  = '0;
                    state_d = BUS_WAIT;
                end else if (bus.bus_reqack) begin
                    state_d = WAIT_RESP;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT_RESP, FILL: begin
                bus_assert_s = 1'b1;
                if (!bus.bus_grant) begin
                    // Abort: the victim stays invalid and the whole line is re-requested
                    beat_d  = '0;
                    state_d = BUS_WAIT;
                end else if (bus.bus_respcyc) begin
                    respack_s = 1'b1;
                    fill_we_s = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        fill_done_s = 1'b1;
                        beat_d      = '0;
                        state_d     = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            FLUSH: begin
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
            hit_cnt_q    <= 32'd0;
            miss_cnt_q   <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            flush_idx_q  <= flush_idx_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Valid bits and round-robin pointers; a line turns invalid on its first fill beat
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            if (state_q == FLUSH) begin
                for (int w = 0; w < WAYS; w++) valid_q[w][flush_idx_q] <= 1'b0;
            end
            if (fill_we_s && (beat_q == '0)) begin
                valid_q[victim_q][miss_idx_s] <= 1'b0;
            end
            if (fill_done_s) begin
                valid_q[victim_q][miss_idx_s] <= 1'b1;
                rr_q[miss_idx_s] <= (rr_q[miss_idx_s] == WAY_W'(WAYS - 1)) ? '0 : rr_q[miss_idx_s] + 1'b1;
            end
        end
    end

    // Line data and tag arrays, written only by fills
    always_ff @(posedge clk) begin
        if (!reset && fill_we_s) begin
            data_q[victim_q][{miss_idx_s, beat_q}] <= bus.bus_resp;
        end
        if (!reset && fill_done_s) begin
            tag_q[victim_q][miss_idx_s] <= miss_tag_s;
        end
    end

    assign resp_valid_o     = resp_valid_q;
    assign resp_data_o      = resp_data_q;
    assign hit_count_o      = hit_cnt_q;
    assign miss_count_o     = miss_cnt_q;
    assign busy_o           = (state_q != IDLE) && !reset;
    assign bus.bus_assert   = bus_assert_s && !reset;
    assign bus.bus_reqcyc   = reqcyc_s && !reset;
    assign bus.bus_req      = (reqcyc_s && !reset) ? BUS_DATA_WIDTH'(miss_addr_q) : '0;
    assign bus.bus_reqtag   = (reqcyc_s && !reset) ? REQ_TAG : '0;
    assign bus.bus_respack  = respack_s && !reset;
endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic [63:0] req_addr_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        busy_o;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    icache_nway_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus_if ();

    icache_nway #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .WAYS(2), .SETS(512), .LINE_BYTES(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .busy_o       (busy_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o),
        .bus          (bus_if.master)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat i of a line seeded with s: upper half s+i, lower half s+0x1000+i
    function automatic logic [63:0] mk(input logic [31:0] s, input int i);
        return {s + 32'(i), s + 32'h0000_1000 + 32'(i)};
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        check_eq({tag, "_resp_data"},  64'(resp_data_o),  64'd0);
        check_eq({tag, "_busy"},       64'(busy_o),       64'd0);
        check_eq({tag, "_hits"},       64'(hit_count_o),  64'd0);
        check_eq({tag, "_misses"},     64'(miss_count_o), 64'd0);
        check_eq({tag, "_bus_assert"}, 64'(bus_if.bus_assert),  64'd0);
        check_eq({tag, "_reqcyc"},     64'(bus_if.bus_reqcyc),  64'd0);
        check_eq({tag, "_bus_req"},    bus_if.bus_req,          64'd0);
        check_eq({tag, "_reqtag"},     64'(bus_if.bus_reqtag),  64'd0);
        check_eq({tag, "_respack"},    64'(bus_if.bus_respack), 64'd0);
    endtask

    task automatic wait_req(input logic [63:0] exp_a);
        int n;
        n = 0;
        #1;
        while (bus_if.bus_reqcyc !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check_eq("req_seen",   64'(bus_if.bus_reqcyc), 64'd1);
        check_eq("bus_req",    bus_if.bus_req,         exp_a);
        check_eq("bus_reqtag", 64'(bus_if.bus_reqtag), 64'h1000);
        bus_if.bus_reqack = 1'b1;
        @(negedge clk);
        bus_if.bus_reqack = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic exp_ack);
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resp    = data;
        #1;
        check_eq("respack", 64'(bus_if.bus_respack), 64'(exp_ack));
        @(negedge clk);
        bus_if.bus_respcyc = 1'b0;
    endtask

    task automatic wait_resp(input logic [31:0] exp);
        int n;
        n = 0;
        #1;
        while (resp_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check_eq("resp_valid", 64'(resp_valid_o), 64'd1);
        check_eq("resp_data",  64'(resp_data_o),  64'(exp));
        req_valid_i = 1'b0;
    endtask

    task automatic miss_fetch(input logic [63:0] a, input logic [31:0] s, input logic [31:0] exp);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        wait_req({a[63:6], 6'd0});
        for (int i = 0; i < 8; i++) send_beat(mk(s, i), 1'b1);
        wait_resp(exp);
    endtask

    task automatic hit_fetch(input logic [63:0] a, input logic [31:0] exp);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1;
        check_eq("hit_no_bus", 64'(bus_if.bus_assert), 64'd0);
        @(negedge clk); #1;
        check_eq("hit_valid", 64'(resp_valid_o), 64'd1);
        check_eq("hit_data",  64'(resp_data_o),  64'(exp));
        req_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int guard;
        logic saw_resp;
        reset = 1'b1; req_valid_i = 1'b0; req_addr_i = 64'd0; flush_i = 1'b0;
        bus_if.bus_grant = 1'b1; bus_if.bus_reqack = 1'b0; bus_if.bus_respcyc = 1'b0;
        bus_if.bus_resp = 64'd0; bus_if.bus_resptag = 13'd0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // Cold miss at 0x1004, then the held request hits
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1004;
        #1;
        check_eq("miss_bus_assert", 64'(bus_if.bus_assert), 64'd1);
        wait_req(64'h1000);
        for (int i = 0; i < 8; i++) send_beat(mk(32'hD000_0000, i), 1'b1);
        wait_resp(32'hD000_0000);
        check_eq("cold_misses", 64'(miss_count_o), 64'd1);
        check_eq("cold_hits",   64'(hit_count_o),  64'd1);

        // Back-to-back hit stream
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1000;
        @(negedge clk); #1;
        check_eq("stream0_valid", 64'(resp_valid_o), 64'd1);
        check_eq("stream0_data",  64'(resp_data_o),  64'hD000_1000);
        req_addr_i = 64'h1008;
        @(negedge clk); #1;
        check_eq("stream1_valid", 64'(resp_valid_o), 64'd1);
        check_eq("stream1_data",  64'(resp_data_o),  64'hD000_1001);
        req_addr_i = 64'h103C;
        @(negedge clk); #1;
        check_eq("stream2_valid", 64'(resp_valid_o), 64'd1);
        check_eq("stream2_data",  64'(resp_data_o),  64'hD000_0007);
        req_valid_i = 1'b0;
        @(negedge clk); #1;
        check_eq("stream_idle", 64'(resp_valid_o), 64'd0);
        check_eq("stream_hits", 64'(hit_count_o),  64'd4);

        // Eviction in set 5: tags 1, 2, then 3 replaces tag 1
        miss_fetch(64'h0_8140, 32'hA000_0000, 32'hA000_1000);
        miss_fetch(64'h1_0140, 32'hB000_0000, 32'hB000_1000);
        miss_fetch(64'h1_8140, 32'hC000_0000, 32'hC000_1000);
        hit_fetch(64'h1_0144, 32'hB000_0000);
        hit_fetch(64'h1_8148, 32'hC000_1001);
        miss_fetch(64'h0_8148, 32'h3A00_0000, 32'h3A00_1001);
        check_eq("evict_misses", 64'(miss_count_o), 64'd5);

        // Grant lost after three beats; the request is reissued on regrant
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h2000;
        wait_req(64'h2000);
        for (int i = 0; i < 3; i++) send_beat(mk(32'hE000_0000, i), 1'b1);
        bus_if.bus_grant = 1'b0;
        send_beat(mk(32'hE000_0000, 3), 1'b0);
        #1;
        check_eq("abort_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
        check_eq("abort_assert", 64'(bus_if.bus_assert), 64'd1);
        repeat (2) @(negedge clk);
        bus_if.bus_grant = 1'b1;
        wait_req(64'h2000);
        for (int i = 0; i < 8; i++) send_beat(mk(32'hF000_0000, i), 1'b1);
        wait_resp(32'hF000_1000);
        check_eq("regrant_misses", 64'(miss_count_o), 64'd6);

        // Flush pulse during the fill, request dropped mid-miss
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h3000;
        wait_req(64'h3000);
        for (int i = 0; i < 2; i++) send_beat(mk(32'h7700_0000, i), 1'b1);
        flush_i     = 1'b1;
        req_valid_i = 1'b0;
        send_beat(mk(32'h7700_0000, 2), 1'b1);
        flush_i = 1'b0;
        for (int i = 3; i < 8; i++) send_beat(mk(32'h7700_0000, i), 1'b1);
        busy_cycles = 0;
        guard       = 0;
        saw_resp    = 1'b0;
        #1;
        while (busy_o !== 1'b1 && guard < 20) begin
            @(negedge clk); #1; guard++;
            if (resp_valid_o === 1'b1) saw_resp = 1'b1;
        end
        while (busy_o === 1'b1 && guard < 2000) begin
            busy_cycles++;
            @(negedge clk); #1; guard++;
            if (resp_valid_o === 1'b1) saw_resp = 1'b1;
        end
        check_eq("flush_cycles",  64'(busy_cycles), 64'd512);
        check_eq("flush_no_resp", 64'(saw_resp),    64'd0);
        miss_fetch(64'h3004, 32'h1234_0000, 32'h1234_0000);
        check_eq("flush_misses", 64'(miss_count_o), 64'd8);

        // Reset while beat 5 is on the bus
        @(negedge clk);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h4000;
        wait_req(64'h4000);
        for (int i = 0; i < 5; i++) send_beat(mk(32'h9900_0000, i), 1'b1);
        reset              = 1'b1;
        req_valid_i        = 1'b0;
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resp    = mk(32'h9900_0000, 5);
        @(negedge clk);
        bus_if.bus_respcyc = 1'b0;
        #1;
        check_zero("mid_rst");
        reset = 1'b0;
        miss_fetch(64'h4000, 32'h5500_0000, 32'h5500_1000);
        check_eq("post_rst_misses", 64'(miss_count_o), 64'd1);
        check_eq("post_rst_hits",   64'(hit_count_o),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
